// File: rtl/aurora_axis_pkg.sv
// Shared definitions for the Aurora AXI4-Stream TX/RX adaptation stages:
// 16-bit half-word keep encodings, the packed 32-bit TX word and the
// helper that coerces an input keep pattern into a legal one.
package aurora_axis_pkg;

    localparam logic [0:1] KEEP_FULL16 = 2'b11;
    localparam logic [0:1] KEEP_HALF16 = 2'b10;

    // One 32-bit word headed for the core, byte 0 in data[0:7].
    typedef struct packed {
        logic [0:31] data;
        logic [0:3]  keep;
        logic        last;
    } tx_word_t;

    // Whether a first half-word is parked waiting for its partner.
    typedef enum logic {
        HALF_EMPTY,
        HALF_HELD
    } pack_state_t;

    // A mid-frame half-word must be full; a closing one may carry one or
    // two bytes but must start at byte 0. Anything else is mapped onto the
    // nearest legal pattern.
    function automatic logic [0:1] fix_keep(input logic [0:1] keep, input logic last);
        if (!last)
            return KEEP_FULL16;
        else if (keep[0])
            return keep;
        else
            return KEEP_HALF16;
    endfunction

endpackage

// File: rtl/aurora_tx_pack16to32_if.sv
// AXI4-Stream bundle with big-endian byte numbering (byte 0 = tdata[0:7]).
// Instantiated with DATA_W=16 on the user side and DATA_W=32 toward the core.
interface aurora_tx_pack16to32_if #(
    parameter int DATA_W = 16
);
    localparam int KEEP_W = DATA_W / 8;

    logic [0:DATA_W-1] tdata;
    logic [0:KEEP_W-1] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_buf2.sv
// Two-entry register FIFO. Entry 0 is always the head presented downstream;
// a simultaneous push and pop keeps the occupancy unchanged. count_next is
// exported so the producer can derive a registered ready from it.
module axis_buf2 #(
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       count_next
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [1:0]       count;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok     = pop & (count != 2'd0);
    assign push_ok    = push & ((count != 2'd2) | pop_ok);
    assign head_valid = (count != 2'd0);
    assign head_data  = entry0;

    // Occupancy after this cycle's push/pop, consumed by the ready logic upstream.
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + 2'd1;
        else if (!push_ok && pop_ok)
            count_next = count - 2'd1;
    end

    // Storage: new words land behind whatever is still queued; a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            count <= count_next;
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0)
                        entry0 <= push_data;
                    else
                        entry1 <= push_data;
                end
                2'b01: begin
                    entry0 <= entry1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/aurora_tx_pack16to32.sv
// Packs a 16-bit AXI4-Stream into 32-bit words for the Aurora core TX port.
// Pairs of half-words are joined big-endian; a frame ending on an odd
// half-word is emitted zero-padded with a 2-byte keep. Words queue in a
// two-entry buffer so the input ready can be a plain register.
module aurora_tx_pack16to32
    import aurora_axis_pkg::*;
#(
    parameter int    CNT_WIDTH   = 16,
    parameter string STRICT_KEEP = "TRUE"
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    aurora_tx_pack16to32_if.slave  s_axis,
    aurora_tx_pack16to32_if.master m_axis,
    output logic [CNT_WIDTH-1:0]   frame_count,
    output logic                   keep_err
);

    localparam bit STRICT_EN = (STRICT_KEEP == "TRUE");

    pack_state_t state;
    logic [0:15] hd;
    logic [0:1]  hk;
    logic        tready_q;

    logic        beat_ok;
    logic [0:1]  keep_fixed;
    logic        keep_bad;
    logic        push;
    tx_word_t    push_word;
    tx_word_t    head_word;
    logic        head_valid;
    logic        pop;
    logic [1:0]  buf_count_next;

    assign beat_ok       = s_axis.tvalid & tready_q;
    assign s_axis.tready = tready_q;

    assign pop           = head_valid & m_axis.tready;
    assign m_axis.tvalid = head_valid;
    assign m_axis.tdata  = head_word.data;
    assign m_axis.tkeep  = head_word.keep;
    assign m_axis.tlast  = head_word.last;

    // Build the word to push: either the held half joined with this beat, or a lone closing half.
    always_comb begin
        keep_fixed = fix_keep(s_axis.tkeep, s_axis.tlast);
        keep_bad   = (keep_fixed != s_axis.tkeep);
        push       = beat_ok & ((state == HALF_HELD) | s_axis.tlast);
        push_word  = '0;
        if (state == HALF_HELD) begin
            push_word.data = {hd, s_axis.tdata};
            push_word.keep = {hk, keep_fixed};
            push_word.last = s_axis.tlast;
        end else begin
            push_word.data = {s_axis.tdata, 16'h0000};
            push_word.keep = {keep_fixed, 2'b00};
            push_word.last = 1'b1;
        end
    end

    axis_buf2 #(
        .WIDTH($bits(tx_word_t))
    ) u_buf (
        .clk        (aclk),
        .rst_n      (aresetn),
        .push       (push),
        .push_data  (push_word),
        .pop        (pop),
        .head_data  (head_word),
        .head_valid (head_valid),
        .count_next (buf_count_next)
    );

    // Half-word holder state, registered ready, sticky keep error and frame counter.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= HALF_EMPTY;
            hd          <= '0;
            hk          <= '0;
            tready_q    <= 1'b0;
            keep_err    <= 1'b0;
            frame_count <= '0;
        end else begin
            tready_q <= (buf_count_next <= 2'd1);
            if (beat_ok) begin
                if (state == HALF_EMPTY && !s_axis.tlast) begin
                    state <= HALF_HELD;
                    hd    <= s_axis.tdata;
                    hk    <= keep_fixed;
                end else begin
                    state <= HALF_EMPTY;
                end
                if (STRICT_EN && keep_bad)
                    keep_err <= 1'b1;
            end
            if (pop && head_word.last)
                frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_aurora_tx_pack16to32.sv
// Testbench for aurora_tx_pack16to32: a table of per-cycle vectors for the
// packing/keep cases, then hand-written sequences for backpressure,
// mid-frame reset and frame_count wrap.
module tb_aurora_tx_pack16to32;

    logic        aclk;
    logic        aresetn;
    logic [15:0] frame_count;
    logic        keep_err;

    int applied;
    int miscompares;

    aurora_tx_pack16to32_if #(.DATA_W(16)) s_bus ();
    aurora_tx_pack16to32_if #(.DATA_W(32)) m_bus ();

    aurora_tx_pack16to32 #(
        .CNT_WIDTH   (16),
        .STRICT_KEEP ("TRUE")
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (s_bus),
        .m_axis      (m_bus),
        .frame_count (frame_count),
        .keep_err    (keep_err)
    );

    // Free-running user_clk, 10 time units per period.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        valid;
        logic [0:15] data;
        logic [0:1]  keep;
        logic        last;
        logic        m_ready;
        logic        exp_s_ready;
        logic        exp_valid;
        logic [0:31] exp_data;
        logic [0:3]  exp_keep;
        logic        exp_last;
        logic [15:0] exp_count;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input logic v, input logic [15:0] d, input logic [1:0] k,
                                   input logic l, input logic mr, input logic esr,
                                   input logic ev, input logic [31:0] ed, input logic [3:0] ek,
                                   input logic el, input logic [15:0] ec, input logic ee);
        vec_t r;
        r.valid       = v;
        r.data        = d;
        r.keep        = k;
        r.last        = l;
        r.m_ready     = mr;
        r.exp_s_ready = esr;
        r.exp_valid   = ev;
        r.exp_data    = ed;
        r.exp_keep    = ek;
        r.exp_last    = el;
        r.exp_count   = ec;
        r.exp_err     = ee;
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        s_bus.tvalid = v.valid;
        s_bus.tdata  = v.data;
        s_bus.tkeep  = v.keep;
        s_bus.tlast  = v.last;
        m_bus.tready = v.m_ready;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("v%0d s_tready", idx), {31'd0, s_bus.tready}, {31'd0, v.exp_s_ready});
        checkVal($sformatf("v%0d m_tvalid", idx), {31'd0, m_bus.tvalid}, {31'd0, v.exp_valid});
        if (v.exp_valid) begin
            checkVal($sformatf("v%0d m_tdata", idx), m_bus.tdata, v.exp_data);
            checkVal($sformatf("v%0d m_tkeep", idx), {28'd0, m_bus.tkeep}, {28'd0, v.exp_keep});
            checkVal($sformatf("v%0d m_tlast", idx), {31'd0, m_bus.tlast}, {31'd0, v.exp_last});
        end
        checkVal($sformatf("v%0d frame_count", idx), {16'd0, frame_count}, {16'd0, v.exp_count});
        checkVal($sformatf("v%0d keep_err", idx), {31'd0, keep_err}, {31'd0, v.exp_err});
    endtask

    task automatic cycle();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic idleInputs();
        s_bus.tvalid = 1'b0;
        s_bus.tdata  = '0;
        s_bus.tkeep  = 2'b00;
        s_bus.tlast  = 1'b0;
    endtask

    task automatic sendBeat(input logic [15:0] d, input logic [1:0] k, input logic l);
        s_bus.tvalid = 1'b1;
        s_bus.tdata  = d;
        s_bus.tkeep  = k;
        s_bus.tlast  = l;
        cycle();
        idleInputs();
    endtask

    // Main sequence: reset, vector table, then the multi-cycle corner cases.
    initial begin
        logic [15:0] acc;
        logic [31:0] total;
        int          cycles;
        int          idx;
        logic        took;
        logic [0:31] drain_words[2];

        applied     = 0;
        miscompares = 0;

        aresetn      = 1'b0;
        idleInputs();
        m_bus.tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);

        checkVal("reset s_tready", {31'd0, s_bus.tready}, 32'd0);
        checkVal("reset m_tvalid", {31'd0, m_bus.tvalid}, 32'd0);
        checkVal("reset m_tdata", m_bus.tdata, 32'd0);
        checkVal("reset m_tkeep", {28'd0, m_bus.tkeep}, 32'd0);
        checkVal("reset frame_count", {16'd0, frame_count}, 32'd0);
        checkVal("reset keep_err", {31'd0, keep_err}, 32'd0);

        aresetn = 1'b1;

        //               v   data      keep   l  mr  esr ev  exp_data       ekeep  el fc  err
        vecs.push_back(mkVec(0, 16'h0000, 2'b00, 0, 1, 1, 0, 32'h0,         4'h0, 0, 0, 0));
        vecs.push_back(mkVec(1, 16'h0011, 2'b11, 0, 1, 1, 0, 32'h0,         4'h0, 0, 0, 0));
        vecs.push_back(mkVec(1, 16'h2233, 2'b11, 0, 1, 1, 1, 32'h00112233,  4'hF, 0, 0, 0));
        vecs.push_back(mkVec(1, 16'h4455, 2'b11, 0, 1, 1, 0, 32'h0,         4'h0, 0, 0, 0));
        vecs.push_back(mkVec(1, 16'h6677, 2'b11, 1, 1, 1, 1, 32'h44556677,  4'hF, 1, 0, 0));
        vecs.push_back(mkVec(0, 16'h0000, 2'b00, 0, 1, 1, 0, 32'h0,         4'h0, 0, 1, 0));
        vecs.push_back(mkVec(1, 16'hA1A2, 2'b11, 0, 1, 1, 0, 32'h0,         4'h0, 0, 1, 0));
        vecs.push_back(mkVec(1, 16'hB1B2, 2'b11, 0, 1, 1, 1, 32'hA1A2B1B2,  4'hF, 0, 1, 0));
        vecs.push_back(mkVec(1, 16'hC1C2, 2'b10, 1, 1, 1, 1, 32'hC1C20000,  4'h8, 1, 1, 0));
        vecs.push_back(mkVec(0, 16'h0000, 2'b00, 0, 1, 1, 0, 32'h0,         4'h0, 0, 2, 0));
        vecs.push_back(mkVec(1, 16'hD1D2, 2'b10, 0, 1, 1, 0, 32'h0,         4'h0, 0, 2, 1));
        vecs.push_back(mkVec(1, 16'hE1E2, 2'b11, 1, 1, 1, 1, 32'hD1D2E1E2,  4'hF, 1, 2, 1));
        vecs.push_back(mkVec(0, 16'h0000, 2'b00, 0, 1, 1, 0, 32'h0,         4'h0, 0, 3, 1));
        vecs.push_back(mkVec(1, 16'hF1F2, 2'b01, 1, 1, 1, 1, 32'hF1F20000,  4'h8, 1, 3, 1));
        vecs.push_back(mkVec(0, 16'h0000, 2'b00, 0, 1, 1, 0, 32'h0,         4'h0, 0, 4, 1));
        vecs.push_back(mkVec(1, 16'h1234, 2'b11, 0, 1, 1, 0, 32'h0,         4'h0, 0, 4, 1));
        vecs.push_back(mkVec(1, 16'h5678, 2'b10, 1, 1, 1, 1, 32'h12345678,  4'hE, 1, 4, 1));
        vecs.push_back(mkVec(0, 16'h0000, 2'b00, 0, 0, 1, 1, 32'h12345678,  4'hE, 1, 4, 1));
        vecs.push_back(mkVec(0, 16'h0000, 2'b00, 0, 1, 1, 0, 32'h0,         4'h0, 0, 5, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            cycle();
            checkOutput(vecs[i], i);
        end

        // Backpressure: core stalled, input offered every cycle.
        $display("[TB] backpressure sequence");
        m_bus.tready = 1'b0;
        acc          = 16'd0;
        s_bus.tvalid = 1'b1;
        s_bus.tkeep  = 2'b11;
        s_bus.tlast  = 1'b0;
        s_bus.tdata  = 16'h0100;
        for (int c = 0; c < 10; c++) begin
            took = s_bus.tready;
            cycle();
            if (took) begin
                acc         = acc + 16'd1;
                s_bus.tdata = 16'h0100 + acc;
            end
        end
        checkVal("stall beats accepted", {16'd0, acc}, 32'd4);
        checkVal("stall s_tready", {31'd0, s_bus.tready}, 32'd0);
        checkVal("stall m_tvalid", {31'd0, m_bus.tvalid}, 32'd1);
        checkVal("stall m_tdata", m_bus.tdata, 32'h01000101);
        checkVal("stall m_tkeep", {28'd0, m_bus.tkeep}, 32'hF);

        idleInputs();
        m_bus.tready   = 1'b1;
        drain_words[0] = 32'h01000101;
        drain_words[1] = 32'h01020103;
        idx            = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_bus.tvalid) begin
                if (idx < 2) begin
                    checkVal($sformatf("drain word %0d", idx), m_bus.tdata, drain_words[idx]);
                end else begin
                    applied++;
                    miscompares++;
                    $display("[TB] FAIL drain extra word: got %h, expected no word", m_bus.tdata);
                end
                idx++;
            end
            cycle();
        end
        checkVal("drain word count", idx, 32'd2);
        checkVal("drain frame_count", {16'd0, frame_count}, 32'd5);

        // Reset with a held half-word and one buffered word.
        $display("[TB] mid-frame reset sequence");
        m_bus.tready = 1'b0;
        sendBeat(16'hAAAA, 2'b11, 1'b0);
        sendBeat(16'hBBBB, 2'b11, 1'b0);
        sendBeat(16'hCCCC, 2'b11, 1'b0);
        checkVal("pre-reset m_tvalid", {31'd0, m_bus.tvalid}, 32'd1);
        aresetn = 1'b0;
        cycle();
        checkVal("mid reset m_tvalid", {31'd0, m_bus.tvalid}, 32'd0);
        checkVal("mid reset frame_count", {16'd0, frame_count}, 32'd0);
        checkVal("mid reset keep_err", {31'd0, keep_err}, 32'd0);
        checkVal("mid reset s_tready", {31'd0, s_bus.tready}, 32'd0);
        checkVal("mid reset m_tdata", m_bus.tdata, 32'd0);
        aresetn      = 1'b1;
        m_bus.tready = 1'b1;
        cycle();
        checkVal("post reset s_tready", {31'd0, s_bus.tready}, 32'd1);
        sendBeat(16'h1111, 2'b11, 1'b0);
        sendBeat(16'h2222, 2'b11, 1'b1);
        checkVal("post reset m_tvalid", {31'd0, m_bus.tvalid}, 32'd1);
        checkVal("post reset m_tdata", m_bus.tdata, 32'h11112222);
        checkVal("post reset m_tlast", {31'd0, m_bus.tlast}, 32'd1);
        cycle();
        checkVal("post reset frame_count", {16'd0, frame_count}, 32'd1);

        // frame_count wrap: 0xFFFF single-beat frames, then one more.
        $display("[TB] frame counter wrap sequence");
        aresetn = 1'b0;
        cycle();
        aresetn = 1'b1;
        cycle();
        s_bus.tvalid = 1'b1;
        s_bus.tkeep  = 2'b11;
        s_bus.tlast  = 1'b1;
        s_bus.tdata  = 16'h5A5A;
        total        = 32'd0;
        cycles       = 0;
        while (total < 32'd65535 && cycles < 70000) begin
            took = s_bus.tready;
            cycle();
            cycles++;
            if (took)
                total = total + 32'd1;
        end
        idleInputs();
        checkVal("wrap beats accepted", total, 32'd65535);
        repeat (3) cycle();
        checkVal("wrap frame_count max", {16'd0, frame_count}, 32'h0000FFFF);
        sendBeat(16'h5A5A, 2'b11, 1'b1);
        repeat (3) cycle();
        checkVal("wrap frame_count zero", {16'd0, frame_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
